// File: rtl/mod16_pkg.sv
// Shared constants and JK-command helpers for the mod-16 JK down counter.
package mod16_pkg;

  localparam int              CNT_W         = 4;
  localparam logic [CNT_W-1:0] CNT_MAX       = 4'hF;
  localparam logic [CNT_W-1:0] RESET_VAL_DEF = 4'hF;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  // Drives a JK stage so that it ends up equal to the given bit.
  function automatic logic [1:0] jk_force(input logic b);
    return {b, ~b};
  endfunction

endpackage

// File: rtl/mod16_down_jk_jkff.sv
// Single JK flip-flop with synchronous active-high reset to a per-instance init value.
import mod16_pkg::*;

module jkff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= INIT;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD: q_q <= q_q;
        JK_CLR:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TOG:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mod16_down_jk.sv
// Synchronous mod-16 down counter built from JK flip-flops, with load, tc and borrow-out.
// Optional feature: define MOD16_DOWN_AUTORELOAD_EN to wrap to the last loaded value.
import mod16_pkg::*;

module mod16_down_jk #(
  parameter logic [CNT_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic             tc,
  output logic             bo
);

  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] reload_s;
  logic [CNT_W-1:0] j_s;
  logic [CNT_W-1:0] k_s;
  logic [CNT_W:0]   low_zero_s;
  logic             is_zero_s;
  logic             underflow_s;
  logic             bo_q;
  logic             bo_d;

`ifdef MOD16_DOWN_AUTORELOAD_EN
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = d;
    end else begin
      reload_d = reload_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= RESET_VAL;
    end else begin
      reload_q <= reload_d;
    end
  end

  assign reload_s = reload_q;
`else
  assign reload_s = CNT_MAX;
`endif

  assign is_zero_s   = (count_s == {CNT_W{1'b0}});
  assign underflow_s = !load && en && is_zero_s;

  // A bit toggles on a decrement exactly when every lower bit is already zero.
  always_comb begin
    low_zero_s    = '0;
    low_zero_s[0] = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      low_zero_s[i+1] = low_zero_s[i] & ~count_s[i];
    end
  end

  always_comb begin
    j_s = '0;
    k_s = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (load) begin
        {j_s[i], k_s[i]} = jk_force(d[i]);
      end else if (underflow_s) begin
        {j_s[i], k_s[i]} = jk_force(reload_s[i]);
      end else if (en) begin
        j_s[i] = low_zero_s[i];
        k_s[i] = low_zero_s[i];
      end else begin
        j_s[i] = 1'b0;
        k_s[i] = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_bit
    jkff #(
      .INIT (RESET_VAL[gi])
    ) u_jkff (
      .clk (clk),
      .rst (rst),
      .j   (j_s[gi]),
      .k   (k_s[gi]),
      .q   (count_s[gi])
    );
  end

  always_comb begin
    bo_d = 1'b0;
    if (underflow_s) begin
      bo_d = 1'b1;
    end else begin
      bo_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bo_q <= 1'b0;
    end else begin
      bo_q <= bo_d;
    end
  end

  assign q  = count_s;
  assign tc = is_zero_s && en;
  assign bo = bo_q;

endmodule

// File: tb/tb_mod16_down_jk.sv
// Scoreboard bench for mod16_down_jk: directed scenarios plus random stimulus vs an arithmetic model.
module tb_mod16_down_jk;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       bo;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       chk;
    logic       tc;
  } tc_exp_t;

  typedef struct {
    logic [3:0] q;
    logic       bo;
  } st_exp_t;

  tc_exp_t tc_queue[$];
  st_exp_t st_queue[$];

  int  m_q;
  int  m_rl;
  bit  m_bo;
  bit  m_known;

  mod16_down_jk dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .bo   (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit r, input bit ld, input bit e, input logic [3:0] dv);
    tc_exp_t te;
    st_exp_t se;
    @(negedge clk);
    rst  = r;
    load = ld;
    en   = e;
    d    = dv;
    te.chk = m_known && !r;
    te.tc  = (m_q == 0) && e;
    tc_queue.push_back(te);
    if (r) begin
      m_q = 15; m_rl = 15; m_bo = 1'b0; m_known = 1'b1;
    end else if (ld) begin
      m_q = int'(dv); m_bo = 1'b0;
`ifdef MOD16_DOWN_AUTORELOAD_EN
      m_rl = int'(dv);
`endif
    end else if (e) begin
      if (m_q == 0) begin
`ifdef MOD16_DOWN_AUTORELOAD_EN
        m_q = m_rl;
`else
        m_q = 15;
`endif
        m_bo = 1'b1;
      end else begin
        m_q = (m_q - 1) % 16;
        m_bo = 1'b0;
      end
    end else begin
      m_bo = 1'b0;
    end
    se.q  = 4'(m_q);
    se.bo = m_bo;
    st_queue.push_back(se);
  endtask

  // Monitor: tc sampled mid-cycle with inputs stable, q/bo just after the edge.
  initial begin
    tc_exp_t te;
    st_exp_t se;
    forever begin
      @(negedge clk);
      #2;
      if (tc_queue.size() > 0) begin
        te = tc_queue.pop_front();
        if (te.chk) begin
          n_tests++;
          if (tc !== te.tc) begin
            n_fail++;
            $display("FAIL tc: got %b expected %b at %0t", tc, te.tc, $time);
          end
        end
      end
      @(posedge clk);
      #1;
      if (st_queue.size() > 0) begin
        se = st_queue.pop_front();
        n_tests++;
        if (q !== se.q || bo !== se.bo) begin
          n_fail++;
          $display("FAIL q_bo: got q=%h bo=%b expected q=%h bo=%b at %0t",
                   q, bo, se.q, se.bo, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    n_tests = 0; n_fail = 0;
    m_q = 0; m_rl = 15; m_bo = 1'b0; m_known = 1'b0;
    rst = 1'b0; en = 1'b0; load = 1'b0; d = 4'h0;

    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h9);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h7);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'h0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    budget = 0;
    while ((st_queue.size() > 0 || tc_queue.size() > 0) && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    n_tests++;
    if (st_queue.size() != 0 || tc_queue.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", st_queue.size() + tc_queue.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
